csc_gather_pack: RTL and testbench

Parametrised streaming successor to the fixed 4-lane gather used in CSC sparse-data handling. It drops zero-valued elements, compacts the survivors in lane order, and re-packs them across input beats into dense LANES-wide output beats. A residual buffer carries partial beats from one cycle to the next, so the output is always full except at the end of a frame. It sits between the CSC data fetch and the MAC feed, with valid/ready handshakes on both sides.

---
 rtl/csc_gather_pkg.sv | 17 +
 rtl/csc_gather_compress.sv | 23 ++
 rtl/csc_gather_pack.sv | 169 ++++++++++++++++
 tb/tb_csc_gather_pack.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/csc_gather_pkg.sv
// Shared types and constants for the CSC gather/pack datapath.
package csc_gather_pkg;

  localparam int unsigned DefLanes = 4;
  localparam int unsigned DefDw    = 6;

  typedef enum logic {
    StRun,
    StFlush
  } state_e;

  // Bits needed to hold a lane count in the range 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/csc_gather_compress.sv
// Combinational compactor: packs non-zero lanes toward lane 0 via a running prefix count.
module csc_gather_compress #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 6,
  parameter int unsigned CW    = 3
) (
  input  logic [LANES*DW-1:0] in_data_i,
  output logic [LANES*DW-1:0] comp_o,
  output logic [CW-1:0]       k_o
);

  always_comb begin
    comp_o = '0;
    k_o    = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (in_data_i[i*DW +: DW] != '0) begin
        comp_o[k_o*DW +: DW] = in_data_i[i*DW +: DW];
        k_o                  = k_o + CW'(1);
      end
    end
  end

endmodule

// File: rtl/csc_gather_pack.sv
// Zero-dropping gather that re-packs survivors into dense LANES-wide beats across input beats.
// Optional statistics counters are enabled with the CSC_GATHER_STAT_EN macro.
module csc_gather_pack
  import csc_gather_pkg::*;
#(
  parameter int unsigned LANES = DefLanes,
  parameter int unsigned DW    = DefDw,
  parameter int unsigned CW    = cnt_width(LANES)
) (
`ifdef CSC_GATHER_STAT_EN
  input  logic                stat_clr,
  output logic [31:0]         stat_zero,
  output logic [31:0]         stat_beats,
`endif
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [LANES*DW-1:0] in_data,
  input  logic                in_last,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [LANES*DW-1:0] out_data,
  output logic [CW-1:0]       out_cnt,
  output logic                out_last
);

  localparam int unsigned BW = LANES * DW;
  localparam int unsigned RW = (LANES - 1) * DW;
  localparam logic [CW:0] LanesC = (CW + 1)'(LANES);

  logic [BW-1:0] comp;
  logic [CW-1:0] k;

  csc_gather_compress #(
    .LANES(LANES),
    .DW   (DW),
    .CW   (CW)
  ) u_compress (
    .in_data_i(in_data),
    .comp_o   (comp),
    .k_o      (k)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [RW-1:0] res_q, res_d;
  logic          out_vld_q, out_vld_d;
  logic [BW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          out_last_q, out_last_d;

  logic          slot_free, accept;
  logic [CW:0]   total;
  logic [2*BW-1:0] seq, res_ext, comp_ext;

  assign slot_free = !out_vld_q || out_rdy;
  assign in_rdy    = slot_free && (state_q == StRun);
  assign accept    = in_vld && in_rdy;
  assign total     = {1'b0, rcnt_q} + {1'b0, k};

  // Residual entries above rcnt are kept zero, so OR-ing the shifted compacted beat is exact.
  always_comb begin
    res_ext            = '0;
    res_ext[RW-1:0]    = res_q;
    comp_ext           = '0;
    comp_ext[BW-1:0]   = comp;
    seq                = res_ext | (comp_ext << (rcnt_q * DW));
  end

  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    res_d      = res_q;
    out_vld_d  = out_vld_q && !out_rdy;
    out_data_d = out_data_q;
    out_cnt_d  = out_cnt_q;
    out_last_d = out_last_q;

    if (state_q == StFlush) begin
      if (slot_free) begin
        out_vld_d            = 1'b1;
        out_data_d           = '0;
        out_data_d[RW-1:0]   = res_q;
        out_cnt_d            = rcnt_q;
        out_last_d           = 1'b1;
        rcnt_d               = '0;
        res_d                = '0;
        state_d              = StRun;
      end
    end else if (accept) begin
      if (!in_last && total < LanesC) begin
        res_d  = seq[RW-1:0];
        rcnt_d = CW'(total);
      end else if (!in_last || total > LanesC) begin
        out_vld_d  = 1'b1;
        out_data_d = seq[BW-1:0];
        out_cnt_d  = CW'(LANES);
        out_last_d = 1'b0;
        res_d      = seq[BW +: RW];
        rcnt_d     = CW'(total - LanesC);
        if (in_last) state_d = StFlush;
      end else begin
        out_vld_d  = 1'b1;
        out_data_d = seq[BW-1:0];
        out_cnt_d  = CW'(total);
        out_last_d = 1'b1;
        res_d      = '0;
        rcnt_d     = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      rcnt_q     <= '0;
      res_q      <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_cnt_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      res_q      <= res_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_cnt_q  <= out_cnt_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_cnt  = out_cnt_q;
  assign out_last = out_last_q;

`ifdef CSC_GATHER_STAT_EN
  logic [31:0] stat_zero_q, stat_zero_d, stat_beats_q, stat_beats_d;
  logic [32:0] zero_sum, beats_sum;

  // Saturating counters; a clear takes priority over a same-cycle increment.
  always_comb begin
    zero_sum  = {1'b0, stat_zero_q} + (accept ? 33'(LANES - 32'(k)) : 33'd0);
    beats_sum = {1'b0, stat_beats_q} + ((out_vld_q && out_rdy) ? 33'd1 : 33'd0);
    stat_zero_d  = zero_sum[32] ? '1 : zero_sum[31:0];
    stat_beats_d = beats_sum[32] ? '1 : beats_sum[31:0];
    if (stat_clr) begin
      stat_zero_d  = '0;
      stat_beats_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_zero_q  <= '0;
      stat_beats_q <= '0;
    end else begin
      stat_zero_q  <= stat_zero_d;
      stat_beats_q <= stat_beats_d;
    end
  end

  assign stat_zero  = stat_zero_q;
  assign stat_beats = stat_beats_q;
`endif

endmodule

// File: tb/tb_csc_gather_pack.sv
// Directed bench for csc_gather_pack with an element-queue reference model and beat scoreboard.
module tb_csc_gather_pack;

  localparam int L  = 4;
  localparam int DW = 6;
  localparam int BW = L * DW;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [BW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_vld;
  logic          out_rdy = 1'b1;
  logic [BW-1:0] out_data;
  logic [CW-1:0] out_cnt;
  logic          out_last;
`ifdef CSC_GATHER_STAT_EN
  logic          stat_clr = 1'b0;
  logic [31:0]   stat_zero, stat_beats;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] pend[$];
  logic [27:0]   exp_q[$];
  logic [27:0]   mon_e;
  logic [27:0]   held;

  always #5 clk = ~clk;

  csc_gather_pack dut (
`ifdef CSC_GATHER_STAT_EN
    .stat_clr  (stat_clr),
    .stat_zero (stat_zero),
    .stat_beats(stat_beats),
`endif
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_data (in_data),
    .in_last (in_last),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_data(out_data),
    .out_cnt (out_cnt),
    .out_last(out_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [BW-1:0] pk(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  task automatic emit(input int n, input logic last);
    logic [BW-1:0] d = '0;
    for (int i = 0; i < n; i++) d[i*DW +: DW] = pend.pop_front();
    exp_q.push_back({last, CW'(n), d});
  endtask

  // Reference: queue all surviving elements, cut full beats, close the frame on last.
  task automatic model_accept(input logic [BW-1:0] d, input logic l);
    for (int i = 0; i < L; i++) if (d[i*DW +: DW] != '0) pend.push_back(d[i*DW +: DW]);
    while (pend.size() > L || (pend.size() == L && !l)) emit(L, 1'b0);
    if (l) emit(pend.size(), 1'b1);
  endtask

  task automatic send(input logic [BW-1:0] d, input logic l);
    int n = 0;
    in_vld  = 1'b1;
    in_data = d;
    in_last = l;
    @(negedge clk);
    while (!in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", 32'(in_rdy), 32'd1);
    if (in_rdy) model_accept(d, l);
    @(posedge clk);
    #1;
    in_vld  = 1'b0;
    in_last = 1'b0;
    in_data = '0;
  endtask

  always @(negedge clk) begin
    if (rst && out_vld && out_rdy) begin
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("beat_data", out_data, mon_e[BW-1:0]);
        check("beat_cnt", out_cnt, mon_e[BW +: CW]);
        check("beat_last", out_last, mon_e[27]);
      end
    end
  end

  initial begin
    int n;
    #12;
    check("rst_out_vld", out_vld, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_rdy", in_rdy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Residual carried across beats, single dense closing beat
    send(pk(0, 4, 0, 3), 1'b0);
    check("s1_no_out", out_vld, 0);
    send(pk(3, 0, 0, 2), 1'b1);

    // Full beat then partial last beat
    send(pk(1, 2, 3, 4), 1'b0);
    send(pk(5, 0, 6, 0), 1'b1);

    // Overflow on last forces a flush cycle
    send(pk(1, 2, 3, 0), 1'b0);
    send(pk(4, 5, 6, 7), 1'b1);
    check("s3_flush_rdy", in_rdy, 0);
    @(posedge clk); #1;
    check("s3_run_rdy", in_rdy, 1);
    @(posedge clk); #1;

    // Backpressure hold
    send(pk(1, 2, 3, 4), 1'b0);
    out_rdy = 1'b0;
    held = {out_last, out_cnt, out_data};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s5_hold_vld", out_vld, 1);
      check("s5_hold_beat", {4'h0, out_last, out_cnt, out_data}, {4'h0, held});
      check("s5_hold_rdy", in_rdy, 0);
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    check("s5_released", out_vld, 0);

    // Empty last beat preserves framing
    send(pk(0, 0, 0, 0), 1'b1);
    @(posedge clk); #1;

    // Reset during FLUSH
    send(pk(1, 2, 3, 0), 1'b0);
    send(pk(4, 5, 6, 7), 1'b1);
    check("s6_in_flush", in_rdy, 0);
    rst = 1'b0;
    #1;
    check("s6_rst_vld", out_vld, 0);
    check("s6_rst_data", out_data, 0);
    check("s6_rst_cnt", out_cnt, 0);
    check("s6_rst_last", out_last, 0);
    exp_q.delete();
    pend.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send(pk(0, 4, 0, 3), 1'b0);
    check("s6_no_out", out_vld, 0);
    send(pk(3, 0, 0, 2), 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    check("idle_out_vld", out_vld, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
